prog_fetch_initiator: RTL and testbench

- Instruction-fetch initiator that drives the program-memory address decoder and collects the returned instruction.
- Holds the fetch PC, presents it on the 32-bit CPU address bus, samples the decoder's registered active-low chip select and then the program memory's registered read data.
- Hands the instruction to the decode stage over a valid/ready handshake.
- Reports an out-of-range fetch (chip select not asserted) as a sticky fault.

---
 rtl/prog_mem_pkg.sv | 22 ++
 rtl/prog_fetch_initiator.sv | 96 +++++++++
 tb/tb_prog_fetch_initiator.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program-memory fetch path: address map of the
// program region and the fetch initiator state encoding.
package prog_mem_pkg;

  localparam logic [31:0] PROG_BASE   = 32'h0000_31B0;
  localparam logic [31:0] PROG_LAST   = 32'h0000_35AF;
  localparam int          PROG_ADDR_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_CS,
    WAIT_DATA,
    HOLD,
    FAULT
  } fetch_state_t;

  function automatic logic in_prog_region(input logic [31:0] addr);
    return (addr >= PROG_BASE) && (addr <= PROG_LAST);
  endfunction

endpackage

// File: rtl/prog_fetch_initiator.sv
// Instruction-fetch initiator: drives the program address decoder, collects the
// registered ROM data and hands each instruction to decode over valid/ready.
module prog_fetch_initiator
  import prog_mem_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PROG_BASE,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [31:0]  pc_addr_out,
  input  logic         cs_p_in,
  input  logic [31:0]  instr_in,
  output logic [31:0]  instr_out,
  output logic [31:0]  instr_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         fault,
  output logic [31:0]  fault_pc,
  output logic         busy,
  output fetch_state_t state_dbg
);

  fetch_state_t state;
  logic [31:0]  pc;

  // The bus address is the PC register itself: stable for the whole ISSUE
  // cycle, and left on the faulting address while in FAULT.
  assign pc_addr_out = pc;
  assign state_dbg   = state;
  assign busy        = (state != IDLE) && (state != FAULT);

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both 1; instr_out/instr_pc stay fixed while valid is high
  // and ready is low, and valid never drops without a transfer except on a
  // redirect or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      fault_pc    <= '0;
    end else if (redirect_valid) begin
      // Redirect beats everything, including a same-cycle handshake in HOLD;
      // any in-flight fetch is dropped because WAIT_* are simply not revisited.
      pc          <= redirect_pc;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      state       <= ISSUE;
    end else begin
      case (state)
        IDLE: begin
          if (en) state <= ISSUE;
        end
        ISSUE: begin
          state <= WAIT_CS;
        end
        WAIT_CS: begin
          if (cs_p_in) begin
            fault    <= 1'b1;
            fault_pc <= pc;
            state    <= FAULT;
          end else begin
            state <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          instr_out   <= instr_in;
          instr_pc    <= pc;
          instr_valid <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            pc          <= pc + PC_STEP;
            state       <= en ? ISSUE : IDLE;
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_fetch_initiator.sv
// Bench for prog_fetch_initiator with a registered address-decoder model and a
// registered 1024-word program ROM.
module tb_prog_fetch_initiator;
  import prog_mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         instr_ready = 1'b0;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = '0;
  logic [31:0]  pc_addr_out;
  logic         cs_p_in;
  logic [31:0]  instr_in;
  logic [31:0]  instr_out;
  logic [31:0]  instr_pc;
  logic         instr_valid;
  logic         fault;
  logic [31:0]  fault_pc;
  logic         busy;
  fetch_state_t state_dbg;

  always #5 clk = ~clk;

  prog_fetch_initiator dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .pc_addr_out   (pc_addr_out),
    .cs_p_in       (cs_p_in),
    .instr_in      (instr_in),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fault         (fault),
    .fault_pc      (fault_pc),
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  // ---------------- decoder + ROM models ----------------
  logic [31:0] rom [1024];
  logic [31:0] dec_off;
  logic        cs_q = 1'b1;
  logic [9:0]  idx_q = '0;
  logic [31:0] data_q = '0;

  assign dec_off  = pc_addr_out - PROG_BASE;
  assign cs_p_in  = cs_q;
  assign instr_in = data_q;

  always @(posedge clk) begin
    cs_q   <= !in_prog_region(pc_addr_out);
    idx_q  <= dec_off[9:0];
    data_q <= rom[idx_q];
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [63:0] exp_q[$];

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    logic [31:0] off;
    off = pc - PROG_BASE;
    return rom[off[9:0]];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, rom_word(pc)});
  endtask

  task automatic expect_next(input string tag);
    logic [63:0] e;
    int n;
    e = exp_q.pop_front();
    n = 0;
    while (instr_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_pc"}, instr_pc, e[63:32]);
    chk({tag, "_data"}, instr_out, e[31:0]);
  endtask

  task automatic accept();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc, input logic with_ready);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    instr_ready    = with_ready;
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
  endtask

  task automatic wait_fault(input string tag, input logic [31:0] pc);
    int n;
    n = 0;
    while (fault !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_fault"}, 32'(fault), 32'd1);
    chk({tag, "_fault_pc"}, fault_pc, pc);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_addr"}, pc_addr_out, pc);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] held_out, held_pc, model_pc, r;
    int t1, t2, mode, dly;

    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rom[0] = 32'hDEAD_0001;

    // reset values
    tick(); tick();
    chk("rst_addr", pc_addr_out, 32'h31B0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_out", instr_out, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // first fetch latency: ISSUE, then valid 3 cycles later
    rst_n = 1'b1;
    en    = 1'b1;
    tick();
    chk("issue_addr", pc_addr_out, 32'h31B0);
    chk("issue_busy", 32'(busy), 32'd1);
    tick(); tick();
    chk("lat_not_yet", 32'(instr_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(instr_valid), 32'd1);
    chk("first_out", instr_out, 32'hDEAD_0001);
    chk("first_pc", instr_pc, 32'h31B0);

    // backpressure in HOLD
    held_out = instr_out;
    held_pc  = instr_pc;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_out", instr_out, held_out);
      chk("hold_pc", instr_pc, held_pc);
    end
    accept();
    chk("acc_valid", 32'(instr_valid), 32'd0);
    chk("acc_next_addr", pc_addr_out, 32'h31B1);

    // throughput with ready held high
    instr_ready = 1'b1;
    push_exp(32'h31B1); push_exp(32'h31B2); push_exp(32'h31B3);
    expect_next("tp0"); t1 = cyc;
    tick();
    expect_next("tp1"); t2 = cyc;
    chk("tp_period1", 32'(t2 - t1), 32'd4);
    tick();
    expect_next("tp2"); t1 = cyc;
    chk("tp_period2", 32'(t1 - t2), 32'd4);
    instr_ready = 1'b0;

    // last location, then the first address past the region
    redirect(32'h35AF, 1'b0);
    chk("redir_addr", pc_addr_out, 32'h35AF);
    chk("redir_valid", 32'(instr_valid), 32'd0);
    push_exp(32'h35AF);
    expect_next("last");
    chk("last_rom", instr_out, rom[1023]);
    accept();
    wait_fault("past_end", 32'h35B0);
    tick(); tick(); tick();
    chk("fault_sticky", 32'(fault), 32'd1);
    chk("fault_novalid", 32'(instr_valid), 32'd0);

    // recover from FAULT
    redirect(32'h3200, 1'b0);
    chk("recover_fault", 32'(fault), 32'd0);
    chk("recover_busy", 32'(busy), 32'd1);
    push_exp(32'h3200);
    expect_next("recover");
    chk("recover_rom50", instr_out, rom[10'h50]);

    // redirect during WAIT_DATA drops the stale data
    accept();
    tick(); tick();
    chk("in_wait_data", 32'(state_dbg), 32'(WAIT_DATA));
    redirect(32'h3300, 1'b0);
    chk("wd_redir_valid", 32'(instr_valid), 32'd0);
    push_exp(32'h3300);
    expect_next("wd_redir");

    // redirect coincident with ready in HOLD
    redirect(32'h3400, 1'b1);
    chk("coin_valid", 32'(instr_valid), 32'd0);
    chk("coin_addr", pc_addr_out, 32'h3400);
    push_exp(32'h3400);
    expect_next("coin");

    // async reset during WAIT_CS
    accept();
    tick();
    chk("in_wait_cs", 32'(state_dbg), 32'(WAIT_CS));
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_out", instr_out, 32'd0);
    chk("arst_pc", instr_pc, 32'd0);
    chk("arst_addr", pc_addr_out, 32'h31B0);
    chk("arst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    push_exp(32'h31B0);
    expect_next("after_rst");

    // en dropped mid-fetch
    accept();
    tick();
    en = 1'b0;
    push_exp(32'h31B1);
    expect_next("en_drop");
    accept();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(instr_valid), 32'd0);
    tick(); tick(); tick();
    chk("idle_busy2", 32'(busy), 32'd0);
    chk("idle_addr", pc_addr_out, 32'h31B2);

    // randomized traffic against the transaction-level model
    en = 1'b1;
    model_pc = PROG_BASE + $urandom_range(0, 900);
    redirect(model_pc, 1'b0);
    push_exp(model_pc);
    for (int it = 0; it < 30; it++) begin
      expect_next("rnd");
      dly = $urandom_range(0, 3);
      for (int k = 0; k < dly; k++) begin
        tick();
        chk("rnd_hold", 32'(instr_valid), 32'd1);
      end
      mode = $urandom_range(0, 3);
      r = PROG_BASE + $urandom_range(0, 900);
      if (mode <= 1) begin
        accept();
        model_pc = model_pc + 32'd1;
      end else if (mode == 2) begin
        redirect(r, 1'b1);
        model_pc = r;
      end else begin
        accept();
        dly = $urandom_range(0, 2);
        for (int k = 0; k < dly; k++) tick();
        redirect(r, 1'b0);
        model_pc = r;
      end
      push_exp(model_pc);
    end
    expect_next("rnd_last");
    exp_q.delete();

    // random out-of-range redirect
    r = ($urandom_range(0, 1) == 0) ? PROG_BASE - 32'($urandom_range(1, 4000))
                                    : PROG_LAST + 32'($urandom_range(1, 4000));
    redirect(r, 1'b0);
    wait_fault("rnd_oor", r);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog timeout");
  end

endmodule
